// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file sizing and writeback port-select encoding.
// Pure definitions: no logic, no latency, no flow control.
package regfile_wb_arbiter_pkg;

  localparam int DEF_REGFILE_SIZE = 32;
  localparam int DEF_ADDR_W       = $clog2(DEF_REGFILE_SIZE);
  localparam int WB_VAL_W         = 32;

  // Round-robin pointer value names the port that wins the next contest
  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, set by reservation, cleared after writeback.
// Set/clear/flush take effect on the next posedge; queries are combinational with no bypass.
module reg_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int REGFILE_SIZE = DEF_REGFILE_SIZE,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_vld,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_vld,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              flush,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_busy,
  output logic              q2_busy
);

  logic [REGFILE_SIZE-1:0] busy_q;
  logic [REGFILE_SIZE-1:0] busy_d;

  // Ordering gives the priority: a reservation beats both a clear and a flush
  always_comb begin
    busy_d = busy_q;
    if (clr_vld) busy_d[clr_idx] = 1'b0;
    if (flush)   busy_d = '0;
    if (set_vld) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign q1_busy = busy_q[q1_addr];
  assign q2_busy = busy_q[q2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port (ALU/load) writeback arbiter with round-robin on contention and a pending-write scoreboard.
// Latency 1 from accepted transfer to wb_we; never stalls a lone requester, loser of a contest waits.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int REGFILE_SIZE = DEF_REGFILE_SIZE,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_dest,
  input  logic [WB_VAL_W-1:0] a_val,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [ADDR_W-1:0]   m_dest,
  input  logic [WB_VAL_W-1:0] m_val,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_dest,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   q1_addr,
  input  logic [ADDR_W-1:0]   q2_addr,
  output logic                q1_busy,
  output logic                q2_busy,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_dest,
  output logic [WB_VAL_W-1:0] wb_val
);

  port_e               ptr_q;
  port_e               ptr_d;
  logic                grant_a;
  logic                grant_m;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_dest;
  logic [WB_VAL_W-1:0] sel_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PORT_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Pointer moves only on a contest, and always to the port that just lost
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    ptr_d   = ptr_q;
    if (a_valid && m_valid) begin
      if (ptr_q == PORT_ALU) begin
        grant_a = 1'b1;
        ptr_d   = PORT_MEM;
      end else begin
        grant_m = 1'b1;
        ptr_d   = PORT_ALU;
      end
    end else begin
      grant_a = a_valid;
      grant_m = m_valid;
    end
  end

  assign a_ready  = rst & grant_a;
  assign m_ready  = rst & grant_m;
  assign xfer     = a_ready | m_ready;
  assign sel_dest = grant_m ? m_dest : a_dest;
  assign sel_val  = grant_m ? m_val  : a_val;

  // Writes to r0 are accepted but never reach the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we   <= 1'b0;
      wb_dest <= '0;
      wb_val  <= '0;
    end else begin
      wb_we <= xfer && (sel_dest != '0);
      if (xfer) begin
        wb_dest <= sel_dest;
        wb_val  <= sel_val;
      end
    end
  end

  reg_scoreboard #(
    .REGFILE_SIZE (REGFILE_SIZE),
    .ADDR_W       (ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_vld (rsv_valid && (rsv_dest != '0)),
    .set_idx (rsv_dest),
    .clr_vld (wb_we),
    .clr_idx (wb_dest),
    .flush   (flush),
    .q1_addr (q1_addr),
    .q2_addr (q2_addr),
    .q1_busy (q1_busy),
    .q2_busy (q2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, m_valid, m_ready;
  logic [4:0]  a_dest, m_dest, rsv_dest, q1_addr, q2_addr, wb_dest;
  logic [31:0] a_val, m_val, wb_val;
  logic        rsv_valid, flush, q1_busy, q2_busy, wb_we;

  int checks = 0;
  int failures = 0;

  // Model state
  bit          mdl_ptr;
  bit          mdl_we;
  logic [4:0]  mdl_dest;
  logic [31:0] mdl_val;
  bit          mdl_busy [32];

  logic last_a_ready, last_m_ready;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_val(a_val),
    .m_valid(m_valid), .m_ready(m_ready), .m_dest(m_dest), .m_val(m_val),
    .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .flush(flush),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_val(wb_val)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_ptr  = 1'b0;
    mdl_we   = 1'b0;
    mdl_dest = '0;
    mdl_val  = '0;
    for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
  endtask

  function automatic bit exp_a_ready();
    if (!a_valid) return 1'b0;
    if (!m_valid) return 1'b1;
    return mdl_ptr == 1'b0;
  endfunction

  function automatic bit exp_m_ready();
    if (!m_valid) return 1'b0;
    if (!a_valid) return 1'b1;
    return mdl_ptr == 1'b1;
  endfunction

  // Called just after a posedge with the inputs that were stable across it
  task automatic model_update();
    bit ta, tm;
    ta = exp_a_ready();
    tm = exp_m_ready();
    if (mdl_we) mdl_busy[mdl_dest] = 1'b0;
    if (flush) for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
    if (rsv_valid && rsv_dest != 0) mdl_busy[rsv_dest] = 1'b1;
    if (a_valid && m_valid) mdl_ptr = ta ? 1'b1 : 1'b0;
    if (ta || tm) begin
      mdl_dest = ta ? a_dest : m_dest;
      mdl_val  = ta ? a_val : m_val;
      mdl_we   = (mdl_dest != 0);
    end else begin
      mdl_we = 1'b0;
    end
  endtask

  // Entered just after a negedge with inputs already driven; returns just after the next negedge
  task automatic cycle();
    #1;
    last_a_ready = a_ready;
    last_m_ready = m_ready;
    chk("a_ready", a_ready, exp_a_ready());
    chk("m_ready", m_ready, exp_m_ready());
    chk("q1_busy_pre", q1_busy, mdl_busy[q1_addr]);
    chk("q2_busy_pre", q2_busy, mdl_busy[q2_addr]);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("wb_we", wb_we, mdl_we);
    if (mdl_we) begin
      chk("wb_dest", wb_dest, mdl_dest);
      chk("wb_val", wb_val, mdl_val);
    end
    chk("q1_busy", q1_busy, mdl_busy[q1_addr]);
    chk("q2_busy", q2_busy, mdl_busy[q2_addr]);
  endtask

  task automatic idle();
    a_valid = 0; m_valid = 0; rsv_valid = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1; a_dest = 5'd3; a_val = 32'h1;
    m_valid = 1; m_dest = 5'd4; m_val = 32'h2;
    rsv_valid = 1; rsv_dest = 5'd3; flush = 0;
    q1_addr = 5'd3; q2_addr = 5'd4;
    model_reset();

    // Reset state, with requests pending
    #12;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_val", wb_val, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_q1_busy", q1_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Lone ALU write
    a_valid = 1; a_dest = 5'd5; a_val = 32'hDEADBEEF;
    cycle();
    chk("alu_ready_lit", last_a_ready, 1);
    chk("alu_we_lit", wb_we, 1);
    chk("alu_dest_lit", wb_dest, 5);
    chk("alu_val_lit", wb_val, 32'hDEADBEEF);
    idle();
    cycle();
    chk("alu_we_off_lit", wb_we, 0);
    chk("alu_dest_hold_lit", wb_dest, 5);
    chk("alu_val_hold_lit", wb_val, 32'hDEADBEEF);

    // Contested for three cycles: ALU, MEM, ALU
    a_valid = 1; a_dest = 5'd1; a_val = 32'hA1;
    m_valid = 1; m_dest = 5'd2; m_val = 32'hB2;
    cycle(); chk("rr0_dest_lit", wb_dest, 1);
    cycle(); chk("rr1_dest_lit", wb_dest, 2);
    cycle(); chk("rr2_dest_lit", wb_dest, 1);
    idle();

    // Reserve 7, ALU writes 7
    q1_addr = 5'd7;
    rsv_valid = 1; rsv_dest = 5'd7;
    cycle();
    chk("sb7_set_lit", q1_busy, 1);
    rsv_valid = 0; a_valid = 1; a_dest = 5'd7; a_val = 32'h77;
    cycle();
    chk("sb7_we_lit", wb_we, 1);
    chk("sb7_busy_during_we_lit", q1_busy, 1);
    idle();
    cycle();
    chk("sb7_clear_lit", q1_busy, 0);

    // Set/clear collision on 9, then flush
    q1_addr = 5'd9;
    rsv_valid = 1; rsv_dest = 5'd9;
    cycle();
    rsv_valid = 0; a_valid = 1; a_dest = 5'd9; a_val = 32'h99;
    cycle();
    idle(); rsv_valid = 1; rsv_dest = 5'd9;
    cycle();
    chk("sb9_set_wins_lit", q1_busy, 1);
    idle(); flush = 1;
    cycle();
    chk("sb9_flush_lit", q1_busy, 0);
    idle();

    // Load to r0
    m_valid = 1; m_dest = 5'd0; m_val = 32'h1234; q1_addr = 5'd0;
    cycle();
    chk("r0_ready_lit", last_m_ready, 1);
    chk("r0_we_lit", wb_we, 0);
    chk("r0_busy_lit", q1_busy, 0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      a_valid   = ($urandom_range(0, 99) < 60);
      m_valid   = ($urandom_range(0, 99) < 60);
      a_dest    = 5'($urandom_range(0, 15));
      m_dest    = 5'($urandom_range(0, 15));
      a_val     = $urandom;
      m_val     = $urandom;
      rsv_valid = ($urandom_range(0, 99) < 40);
      rsv_dest  = 5'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 99) < 5);
      q1_addr   = 5'($urandom_range(0, 15));
      q2_addr   = 5'($urandom_range(0, 15));
      cycle();
    end

    // Async reset between edges while a write is in flight
    idle();
    rsv_valid = 1; rsv_dest = 5'd3; q1_addr = 5'd3; q2_addr = 5'd4;
    cycle();
    idle();
    a_valid = 1; a_dest = 5'd3; a_val = 32'h33;
    m_valid = 1; m_dest = 5'd4; m_val = 32'h44;
    if (mdl_ptr) cycle();
    #1;
    @(posedge clk);
    model_update();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wb_we", wb_we, 0);
    chk("arst_wb_dest", wb_dest, 0);
    chk("arst_wb_val", wb_val, 0);
    chk("arst_q1_busy", q1_busy, 0);
    chk("arst_a_ready", a_ready, 0);
    chk("arst_m_ready", m_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("post_rst_alu_first_lit", last_a_ready, 1);
    chk("post_rst_mem_wait_lit", last_m_ready, 0);
    chk("post_rst_dest_lit", wb_dest, 3);
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter REGFILE_SIZE, default 32, number of architectural registers; the same value as the shared REGFILE_SIZE define.
REQ-002 Parameter ADDR_W, default 5, register index width; SHALL equal log2(REGFILE_SIZE).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 a_valid/a_ready  in/out  1/1  ALU writeback handshake.
REQ-006 a_dest/a_val  input  ADDR_W/32  ALU destination index and result.
REQ-007 m_valid/m_ready  in/out  1/1  memory (load) writeback handshake.
REQ-008 m_dest/m_val  input  ADDR_W/32  load destination index and data.
REQ-009 rsv_valid/rsv_dest  input  1/ADDR_W  issue-stage destination reservation.
REQ-010 flush  input  1  clears all reservations.
REQ-011 q1_addr/q2_addr  input  ADDR_W  scoreboard query indices.
REQ-012 q1_busy/q2_busy  output  1  register has a pending write.
REQ-013 wb_we/wb_dest/wb_val  output  1/ADDR_W/32  register-file write port; register file samples it on negedge.

Function
REQ-014 A transfer SHALL occur on a posedge where valid and ready are both 1.
REQ-015 Only one valid port: its ready SHALL be 1 combinationally; the block never back-pressures a lone requester.
REQ-016 Both valid: grant SHALL follow a 1-bit round-robin pointer (0=ALU, 1=mem); loser's ready SHALL be 0.
REQ-017 Pointer SHALL toggle only after a contested grant, to point at the loser; uncontested grants leave it unchanged.
REQ-018 Accepted transfer SHALL load the output stage on the same posedge: wb_we=1, wb_dest, wb_val valid for exactly one cycle (latency 1).
REQ-019 No transfer in a cycle: wb_we SHALL be 0 next cycle; wb_dest/wb_val hold their last values.
REQ-020 Transfer with dest 0 SHALL be accepted, SHALL produce wb_we=0, and SHALL not affect the scoreboard.
REQ-021 busy[REGFILE_SIZE-1:0]: rsv_valid with nonzero rsv_dest SHALL set busy[rsv_dest] at posedge; busy[0] is constantly 0.
REQ-022 busy[wb_dest] SHALL clear at the posedge ending a cycle with wb_we=1 (after the register file write has landed).
REQ-023 Set and clear of the same index on the same edge: set SHALL win.
REQ-024 Reserving an already-busy index SHALL leave it busy (no count).
REQ-025 flush SHALL clear all busy bits on posedge; an in-flight wb_we still completes; rsv_valid in the same cycle SHALL win for its index.
REQ-026 q1_busy/q2_busy SHALL be combinational reads of busy[q*_addr], with no bypass.

Reset
REQ-027 rst=0 SHALL immediately force wb_we=0, wb_dest=0, wb_val=0, busy=0, pointer=0 (ALU first).
REQ-028 During reset, a_ready and m_ready SHALL be 0; a transfer in flight when reset asserts SHALL be discarded.
REQ-029 First transfer SHALL be possible on the first posedge after rst deasserts.

Structure
REQ-030 REGFILE_SIZE, ADDR_W and the port-select encoding (ALU=0, MEM=1) SHALL live in the shared defines file.
REQ-031 Scoreboard SHALL be a sub-module reg_scoreboard (set/clear/flush/two query ports); arbiter and output stage stay in the top.

Verification
REQ-032 ALU only: a_dest=5, a_val=0xDEADBEEF for one cycle -> a_ready=1; next cycle wb_we=1, wb_dest=5, wb_val=0xDEADBEEF; then wb_we=0.
REQ-033 Contested: both valid 3 cycles (a_dest=1, m_dest=2) -> grants ALU, MEM, ALU; wb_dest sequence 1,2,1.
REQ-034 Scoreboard: rsv 7; ALU writes 7 -> q1_busy(7)=1 through the wb_we cycle, 0 the cycle after.
REQ-035 Collision: wb_we on dest 9 while rsv_dest=9 -> busy[9] stays 1; flush next cycle -> 0.
REQ-036 Dest 0: m_dest=0, m_val=0x1234 -> m_ready=1, wb_we stays 0, q1_busy(0)=0.
REQ-037 Async reset mid-transfer: rst=0 between edges -> wb_we=0 and busy=0 before next posedge; pointer=0 after release.
